seq_tx: RTL
===========

# seq_tx

Serial frame transmitter; the sending end of the single-bit serial line that the "110" sequence detector monitors. Accepts a parallel word over a valid/ready handshake. Emits a fixed `1,1,0` preamble, then the word MSB-first, one bit per clock, on a single registered output. Sits upstream of the detector and drives its serial input in both the system and the bench.

## Interface
Parameters:
- `DATA_W`, default 8: payload width in bits; legal range 1..32.

Ports:
- `clk`  input  1  sole clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_in`  input  DATA_W  payload word; sampled only on an accepted handshake.
- `data_valid`  input  1  upstream has a word on `data_in`.
- `data_ready`  output  1  block can accept a word this cycle.
- `tx_bit`  output  1  serial line, registered.
- `tx_active`  output  1  high while a frame bit is on `tx_bit`.
- `frame_done`  output  1  one-cycle pulse marking the last bit of a frame.

## Operation
- State machine with three states:
  - IDLE
  - PRE: preamble, 3 bits.
  - DATA: DATA_W bits, plus a parity bit when enabled.
- Down-counter `bit_cnt`, width `$clog2(DATA_W+2)`. Shift register `shreg`, DATA_W bits.
- `data_ready` = (state == IDLE) and not `reset`. Combinational from registered state.
- Accept condition: `data_valid && data_ready` at a rising edge.
  - On accept, `data_in` is latched into `shreg`.
  - State goes to PRE and the preamble index is set to 0.
- PRE drives 1, 1, 0 on successive cycles, then moves to DATA with `bit_cnt` = DATA_W - 1.
- DATA drives `shreg[DATA_W-1]` and shifts left each cycle, so bits go out MSB first.
  - When `bit_cnt` = 0 and parity is disabled, the next state is IDLE.
- IDLE: `tx_bit` = 0, `tx_active` = 0. The line idles low.
- While not in IDLE, `data_valid` is ignored and `data_in` may change freely.
- Frame length L = 3 + DATA_W (+1 with parity).
- Reset values:
  - state = IDLE, `tx_bit` = 0, `tx_active` = 0, `frame_done` = 0.
  - `shreg` = 0, `bit_cnt` = 0.
  - `data_ready` = 0 while `reset` is asserted, and 1 in the first cycle after release.
- Reset mid-frame aborts immediately: `tx_bit` drops to 0 asynchronously, and the remainder of the frame is discarded. No `frame_done` is issued for an aborted frame.

## Timing
- Handshake accepted at edge N. `tx_bit` carries:
  - preamble on cycles N+1..N+3: values 1, 1, 0;
  - payload MSB..LSB on cycles N+4..N+3+DATA_W;
  - parity bit, if enabled, on the following cycle.
- `tx_active` is high for exactly L consecutive cycles, starting at N+1.
- `frame_done` is high during the cycle the last frame bit is on `tx_bit`, coincident with it.
- After the last bit, the block spends at least 1 cycle in IDLE, with `tx_bit` = 0 and `data_ready` = 1.
  - A new accept can occur at the first edge in IDLE.
  - Back-to-back frames are therefore separated by exactly one idle-low bit.
- Frame throughput: one frame per L+1 cycles maximum.
- `data_valid` held high continuously gives back-to-back frames with the one-bit gap. No word is dropped or duplicated.

## Configuration
- `SEQ_TX_PARITY_EN` defined:
  - After the LSB, one extra bit is sent: even parity, i.e. the XOR of all DATA_W payload bits.
  - The parity is computed at accept time and stored in a 1-bit register.
  - L = DATA_W + 4, and `frame_done` marks the parity bit.
- Undefined: no parity bit, no parity register, L = DATA_W + 3.

## Test plan
- Reset, then `data_valid` = 0 for 10 cycles:
  - `tx_bit` = 0, `tx_active` = 0 and `frame_done` = 0 throughout;
  - `data_ready` = 0 during reset and 1 afterwards.
- DATA_W = 8, single word 0xA5, parity off:
  - `tx_bit` = 1,1,0,1,0,1,0,0,1,0,1 on cycles N+1..N+11;
  - `frame_done` high only at N+11; `tx_bit` = 0 at N+12.
- `data_valid` held high with words 0xFF then 0x00:
  - frames 1,1,0,1×8 then 0 gap, then 1,1,0,0×8;
  - the second accept occurs exactly at N+12.
- `SEQ_TX_PARITY_EN`, word 0x07 (three ones):
  - payload 0,0,0,0,0,1,1,1 followed by parity 1;
  - `frame_done` at N+12, `tx_active` high for 12 cycles.
- Reset asserted at N+6, mid-payload:
  - `tx_bit` and `tx_active` go 0 immediately, with no `frame_done`;
  - after release, a new word 0x3C is transmitted correctly from its preamble.
- Loopback into the sequence detector, word 0x00, parity off: the detector output pulses exactly once, one cycle after the preamble's trailing 0 appears on `tx_bit`.

Source files
------------

// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter.
// Takes a DATA_W-bit word over a valid/ready handshake and sends it on one
// registered line. Each frame is a fixed 1,1,0 preamble followed by the
// payload, MSB first. The line idles low.
// Optional feature macro: SEQ_TX_PARITY_EN. When defined, one even-parity
// bit is appended after the LSB.
// The state register runs one cycle ahead of the line. Each state decodes the
// bit that the output flops present on the next cycle. This lets data_ready
// rise while the last bit is still on the line, so back-to-back frames are
// separated by exactly one idle-low bit.
module seq_tx #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              tx_bit,
   output logic              tx_active,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(DATA_W + 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t            r_state,     w_state_next;
   logic [CNT_W-1:0]  r_bit_cnt,   w_bit_cnt_next;
   logic [1:0]        r_pre_idx,   w_pre_idx_next;
   logic [DATA_W-1:0] r_shreg,     w_shreg_next;
   logic              r_tx_bit,    w_tx_bit_next;
   logic              r_tx_active, w_tx_active_next;
   logic              r_frame_done, w_frame_done_next;
   logic              w_accept;
   logic              w_last;

`ifdef SEQ_TX_PARITY_EN
   // The parity is captured at accept time. r_par_phase marks the extra
   // DATA slot that drives the parity bit after the payload has gone out.
   logic              r_parity,    w_parity_next;
   logic              r_par_phase, w_par_phase_next;
   assign w_last = (r_state == S_DATA) && r_par_phase;
`else
   assign w_last = (r_state == S_DATA) && (r_bit_cnt == '0);
`endif

   assign data_ready = (r_state == S_IDLE) && !reset;
   assign w_accept   = data_valid && data_ready;
   assign tx_bit     = r_tx_bit;
   assign tx_active  = r_tx_active;
   assign frame_done = r_frame_done;

   // State, counters and output flops. Reset clears them asynchronously, so an
   // in-flight frame is dropped and the line goes low at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= '0;
         r_pre_idx    <= '0;
         r_shreg      <= '0;
         r_tx_bit     <= 1'b0;
         r_tx_active  <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
         r_parity     <= 1'b0;
         r_par_phase  <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_next;
         r_bit_cnt    <= w_bit_cnt_next;
         r_pre_idx    <= w_pre_idx_next;
         r_shreg      <= w_shreg_next;
         r_tx_bit     <= w_tx_bit_next;
         r_tx_active  <= w_tx_active_next;
         r_frame_done <= w_frame_done_next;
`ifdef SEQ_TX_PARITY_EN
         r_parity     <= w_parity_next;
         r_par_phase  <= w_par_phase_next;
`endif
      end
   end

   // Next-state logic and the line value that the current state produces on
   // the following cycle.
   always_comb begin
      w_state_next      = r_state;
      w_bit_cnt_next    = r_bit_cnt;
      w_pre_idx_next    = r_pre_idx;
      w_shreg_next      = r_shreg;
      w_tx_bit_next     = 1'b0;
      w_tx_active_next  = 1'b0;
      w_frame_done_next = 1'b0;
`ifdef SEQ_TX_PARITY_EN
      w_parity_next     = r_parity;
      w_par_phase_next  = r_par_phase;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next   = S_PRE;
               w_pre_idx_next = 2'd0;
               w_shreg_next   = data_in;
`ifdef SEQ_TX_PARITY_EN
               w_parity_next    = ^data_in;
               w_par_phase_next = 1'b0;
`endif
            end
         end
         S_PRE: begin
            // Preamble 1,1,0: only the third slot drives a zero.
            w_tx_active_next = 1'b1;
            w_tx_bit_next    = (r_pre_idx != 2'd2);
            if (r_pre_idx == 2'd2) begin
               w_state_next   = S_DATA;
               w_bit_cnt_next = CNT_W'(DATA_W - 1);
            end else begin
               w_pre_idx_next = r_pre_idx + 2'd1;
            end
         end
         S_DATA: begin
            w_tx_active_next  = 1'b1;
            w_frame_done_next = w_last;
`ifdef SEQ_TX_PARITY_EN
            if (r_par_phase) begin
               w_tx_bit_next    = r_parity;
               w_par_phase_next = 1'b0;
               w_state_next     = S_IDLE;
            end else begin
               w_tx_bit_next = r_shreg[DATA_W-1];
               w_shreg_next  = r_shreg << 1;
               if (r_bit_cnt == '0)
                  w_par_phase_next = 1'b1;
               else
                  w_bit_cnt_next = r_bit_cnt - CNT_W'(1);
            end
`else
            w_tx_bit_next = r_shreg[DATA_W-1];
            w_shreg_next  = r_shreg << 1;
            if (r_bit_cnt == '0)
               w_state_next = S_IDLE;
            else
               w_bit_cnt_next = r_bit_cnt - CNT_W'(1);
`endif
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

endmodule
